// File: rtl/xcorr_peak_finder.sv
// Streams one signed correlation sample per lag and commits the lag index and
// value of the largest sample; the earliest lag wins on ties.
module xcorr_peak_finder #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 16
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic [31:0]              ctrl_word,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     s_ready,
    output logic [31:0]              max_sequence_x,
    output logic [31:0]              max_sequence_y,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t                   state;
    state_t                   state_nxt;
    logic                     start_q;
    logic                     start_evt;
    logic                     vld_p0;
    logic                     last_p0;
    logic                     ctrl_unused;
    logic [IDX_W-1:0]         lag_n_in;
    logic [IDX_W-1:0]         lag_n;
    logic [IDX_W-1:0]         lag_cnt;
    logic [IDX_W-1:0]         peak_idx;
    logic signed [DATA_W-1:0] peak_val;

    function automatic logic [31:0] zext_idx(input logic [IDX_W-1:0] idx);
        return 32'(idx);
    endfunction

    function automatic logic [31:0] sext_val(input logic signed [DATA_W-1:0] val);
        return 32'(val);
    endfunction

    assign ctrl_unused = ^ctrl_word;
    assign lag_n_in    = ctrl_word[IDX_W+15:16];
    assign start_evt   = ctrl_word[0] & ~start_q;
    assign s_ready     = (state == RUN);
    assign busy        = (state != IDLE);
    assign vld_p0      = s_valid & s_ready;
    assign last_p0     = (lag_cnt == (lag_n - IDX_ONE));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_evt) begin
                    state_nxt = (lag_n_in != '0) ? RUN : FINISH;
                end
            end
            RUN: begin
                if (vld_p0 && last_p0) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state          <= IDLE;
            start_q        <= 1'b0;
            lag_n          <= '0;
            lag_cnt        <= '0;
            peak_idx       <= '0;
            peak_val       <= '0;
            done           <= 1'b0;
            max_sequence_x <= '0;
            max_sequence_y <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= ctrl_word[0];
            done    <= (state == FINISH);

            if (state == IDLE && start_evt) begin
                lag_n    <= lag_n_in;
                lag_cnt  <= '0;
                peak_idx <= '0;
                peak_val <= '0;
            end

            // accept stage: the first sample of a run loads the peak unconditionally
            if (vld_p0) begin
                lag_cnt <= lag_cnt + IDX_ONE;
                if (lag_cnt == '0 || s_data > peak_val) begin
                    peak_val <= s_data;
                    peak_idx <= lag_cnt;
                end
            end

            // commit stage
            if (state == FINISH) begin
                max_sequence_x <= zext_idx(peak_idx);
                max_sequence_y <= sext_val(peak_val);
            end
        end
    end

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// Scoreboard bench for xcorr_peak_finder: directed scenarios plus random runs
// checked against a max-then-first-index reference model.
module tb_xcorr_peak_finder;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 16;

    typedef logic signed [31:0] smp_q_t[$];
    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          cyc;
    } exp_t;

    logic                     hclk      = 1'b0;
    logic                     hresetn   = 1'b0;
    logic [31:0]              ctrl_word = '0;
    logic                     s_valid   = 1'b0;
    logic signed [DATA_W-1:0] s_data    = '0;
    logic                     s_ready;
    logic                     busy;
    logic                     done;
    logic [31:0]              max_sequence_x;
    logic [31:0]              max_sequence_y;

    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    smp_q_t      cur;
    logic [31:0] last_x = '0;
    logic [31:0] last_y = '0;

    xcorr_peak_finder #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .hclk           (hclk),
        .hresetn        (hresetn),
        .ctrl_word      (ctrl_word),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .max_sequence_x (max_sequence_x),
        .max_sequence_y (max_sequence_y),
        .busy           (busy),
        .done           (done)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Peak value is the plain maximum; its index is the lowest lag holding it.
    function automatic exp_t model(input smp_q_t smp, input int done_cyc);
        exp_t e;
        logic signed [31:0] mx;
        e.x   = '0;
        e.y   = '0;
        e.cyc = done_cyc;
        if (smp.size() != 0) begin
            mx = smp[0];
            foreach (smp[k]) if (smp[k] > mx) mx = smp[k];
            for (int k = smp.size() - 1; k >= 0; k--) if (smp[k] == mx) e.x = 32'(k);
            e.y = mx;
        end
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge hclk);
            #1;
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_unexpected: got done=1, expected done=0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("peak_x", max_sequence_x, e.x);
                    check("peak_y", max_sequence_y, e.y);
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    last_x = e.x;
                    last_y = e.y;
                end
            end else begin
                check("hold_x", max_sequence_x, last_x);
                check("hold_y", max_sequence_y, last_y);
            end
        end
    end

    task automatic start_run(input int n);
        smp_q_t none;
        @(negedge hclk);
        ctrl_word = (32'(n) << 16) | 32'd1;
        if (n == 0) exp_q.push_back(model(none, cyc + 2));
        @(negedge hclk);
        ctrl_word = '0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(s_ready), (n != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic stream(input smp_q_t smp, input int gap_pct, input int repulse_at, input bit commit);
        int i;
        int guard;
        i     = 0;
        guard = 0;
        while (i < smp.size()) begin
            ctrl_word = '0;
            if ($urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = $urandom;
            end else begin
                s_valid = 1'b1;
                s_data  = smp[i];
                if (i == repulse_at) ctrl_word = 32'h0002_0001;
            end
            if (s_valid && s_ready) begin
                i++;
                if (commit && i == smp.size()) exp_q.push_back(model(smp, cyc + 2));
            end
            @(negedge hclk);
            guard++;
            if (guard > 1000) begin
                n_chk++;
                n_fail++;
                $display("FAIL stream_timeout: accepted %0d of %0d samples", i, smp.size());
                break;
            end
        end
        s_valid   = 1'b0;
        ctrl_word = '0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge hclk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: %0d results still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        check("busy_idle", 32'(busy), 32'd0);
        check("ready_idle", 32'(s_ready), 32'd0);
    endtask

    task automatic run(input smp_q_t smp, input int gap_pct, input int repulse_at);
        start_run(smp.size());
        if (smp.size() != 0) stream(smp, gap_pct, repulse_at, 1'b1);
        wait_idle();
    endtask

    initial begin : stim
        logic signed [31:0] v;
        int n;

        repeat (2) @(negedge hclk);
        check("rst_x", max_sequence_x, 32'd0);
        check("rst_y", max_sequence_y, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        hresetn = 1'b1;

        cur.delete();
        cur.push_back(3); cur.push_back(-1); cur.push_back(7); cur.push_back(2);
        run(cur, 0, -1);

        cur.delete();
        cur.push_back(5); cur.push_back(5); cur.push_back(5);
        run(cur, 0, -1);

        // a large sample offered while idle must not reach the peak
        for (int k = 0; k < 3; k++) begin
            @(negedge hclk);
            s_valid = 1'b1;
            s_data  = 32'sh7FFF_FFFF;
            check("ready_idle_offer", 32'(s_ready), 32'd0);
        end
        cur.delete();
        cur.push_back(32'h8000_0000); cur.push_back(32'hFFFF_FFFF);
        run(cur, 0, -1);

        cur.delete();
        cur.push_back(10); cur.push_back(20); cur.push_back(30); cur.push_back(25); cur.push_back(40);
        run(cur, 40, 2);

        cur.delete();
        run(cur, 0, -1);

        // reset mid-run, start bit held through reset
        cur.delete();
        cur.push_back(11); cur.push_back(22);
        start_run(4);
        stream(cur, 0, -1, 1'b0);
        hresetn   = 1'b0;
        ctrl_word = (32'd3 << 16) | 32'd1;
        last_x    = '0;
        last_y    = '0;
        @(negedge hclk);
        check("midrst_x", max_sequence_x, 32'd0);
        check("midrst_y", max_sequence_y, 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(s_ready), 32'd0);
        hresetn = 1'b1;
        @(negedge hclk);
        check("relaunch_busy", 32'(busy), 32'd1);
        check("relaunch_ready", 32'(s_ready), 32'd1);
        ctrl_word = '0;
        cur.delete();
        cur.push_back(-5); cur.push_back(9); cur.push_back(9);
        stream(cur, 20, -1, 1'b1);
        wait_idle();

        for (int r = 0; r < 30; r++) begin
            n = int'($urandom_range(12));
            cur.delete();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(1) == 1) v = $urandom_range(6) - 3;
                else v = $urandom;
                cur.push_back(v);
            end
            run(cur, int'($urandom_range(50)), -1);
        end

        repeat (3) @(negedge hclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
